// File: rtl/definesPkg.sv
// Shared definitions for the 16-bit pipelined CPU: bundle widths, opcode
// encodings, the pipeline bundle layouts and register-write decode helpers.
package definesPkg;

   localparam int RR_EX_WIDTH = 65;
   localparam int EX_WB_WIDTH = 82;

   // Opcode lives in instr[4:0]. Control transfers occupy x1xxx, with bit 4
   // selecting the immediate (PC-relative) form over the register form.
   typedef enum logic [4:0] {
      OP_NOP   = 5'b00000,
      OP_MV    = 5'b00001,
      OP_ADD   = 5'b00010,
      OP_SUB   = 5'b00011,
      OP_CMP   = 5'b00100,
      OP_LD    = 5'b00101,
      OP_ST    = 5'b00110,
      OP_JR    = 5'b01000,
      OP_JZ    = 5'b01001,
      OP_JN    = 5'b01010,
      OP_CALLR = 5'b01100,
      OP_MVI   = 5'b10001,
      OP_ADDI  = 5'b10010,
      OP_SUBI  = 5'b10011,
      OP_CMPI  = 5'b10100,
      OP_MVHI  = 5'b10101,
      OP_J     = 5'b11000,
      OP_JZI   = 5'b11001,
      OP_JNI   = 5'b11010,
      OP_CALL  = 5'b11100
   } opcode_e;

   typedef enum logic [1:0] {
      ALU_PASS_B = 2'd0,
      ALU_ADD    = 2'd1,
      ALU_SUB    = 2'd2,
      ALU_HI     = 2'd3
   } alu_op_e;

   // Register-read to execute bundle; PC is already instr address + 2.
   typedef struct packed {
      logic [15:0] pc;
      logic        valid;
      logic [15:0] data1;
      logic [15:0] data2;
      logic [15:0] instr;
   } rr_ex_t;

   // Execute to writeback bundle.
   typedef struct packed {
      logic        taken;
      logic [15:0] pc;
      logic        valid;
      logic [15:0] data1;
      logic [15:0] data2;
      logic [15:0] alu_out;
      logic [15:0] instr;
   } ex_wb_t;

   // True for calls, whose written value is the return address (PC), not ALUout.
   function automatic logic is_call(input logic [15:0] instr);
      return (instr[4:0] == OP_CALL) || (instr[4:0] == OP_CALLR);
   endfunction

   // True when the instruction commits a register at writeback. Loads also
   // write, but their data arrives from memory and is never forwarded here.
   function automatic logic writes_reg(input logic [15:0] instr);
      logic w;
      case (instr[4:0])
         OP_MV, OP_ADD, OP_SUB, OP_MVI, OP_ADDI, OP_SUBI, OP_MVHI,
         OP_CALL, OP_CALLR: w = 1'b1;
         default:           w = 1'b0;
      endcase
      return w;
   endfunction

   // Destination register: r7 for calls (link register), Rx otherwise.
   function automatic logic [2:0] dest_reg(input logic [15:0] instr);
      return is_call(instr) ? 3'd7 : instr[7:5];
   endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational 16-bit ALU for the execute stage. Arithmetic is modulo 2^16;
// the carry is dropped. z/n describe the result for the flag register.
module datapath_alu
   import definesPkg::*;
(
   input  alu_op_e     op,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] result,
   output logic        z,
   output logic        n
);

   // Select the result for the requested operation.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      result = b;
      case (op)
         ALU_PASS_B: result = b;
         ALU_ADD:    result = a + b;
         ALU_SUB:    result = a - b;
         ALU_HI:     result = {b[7:0], a[7:0]};
         default:    result = b;
      endcase
   end

   assign z = (result == 16'h0000);
   assign n = result[15];

endmodule

// File: rtl/datapath_execute.sv
// Execute stage: operand forwarding from the EX_WB register, ALU and N/Z
// flags, load/store strobes, and resolution of jumps, branches and calls.
module datapath_execute
   import definesPkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [RR_EX_WIDTH-1:0] RR_EX,
   input  logic                   i_stall,
   output logic [EX_WB_WIDTH-1:0] EX_WB,
   output logic                   o_pc_redirect,
   output logic [15:0]            o_pc_target,
   output logic                   o_flush,
   output logic [15:0]            o_ldst_addr,
   output logic [15:0]            o_ldst_wrdata,
   output logic                   o_ldst_rd,
   output logic                   o_ldst_wr
);

   rr_ex_t      rr;
   ex_wb_t      ex_q;
   ex_wb_t      ex_d;
   logic        z_q;
   logic        n_q;

   logic        fwd_en;
   logic [2:0]  fwd_dst;
   logic [15:0] fwd_val;
   logic [2:0]  rx;
   logic [2:0]  ry;
   logic [15:0] op_x;
   logic [15:0] op_y;
   logic [15:0] simm8;
   logic [15:0] imm_target;

   alu_op_e     alu_op;
   logic [15:0] alu_b;
   logic [15:0] alu_res;
   logic        alu_z;
   logic        alu_n;
   logic        sets_flags;
   logic        taken_raw;
   logic [15:0] target;
   logic        is_ld;
   logic        is_st;
   logic        fire;

   assign rr    = rr_ex_t'(RR_EX);
   assign EX_WB = ex_q;

   assign rx         = rr.instr[7:5];
   assign ry         = rr.instr[10:8];
   assign simm8      = {{8{rr.instr[15]}}, rr.instr[15:8]};
   assign imm_target = rr.pc + {{4{rr.instr[15]}}, rr.instr[15:5], 1'b0};

   // The instruction held in EX_WB is one step older than the one in execute;
   // its result has not reached the register file, so bypass it.
   assign fwd_en  = ex_q.valid && writes_reg(ex_q.instr);
   assign fwd_dst = dest_reg(ex_q.instr);
   assign fwd_val = is_call(ex_q.instr) ? ex_q.pc : ex_q.alu_out;
   assign op_x    = (fwd_en && (fwd_dst == rx)) ? fwd_val : rr.data1;
   assign op_y    = (fwd_en && (fwd_dst == ry)) ? fwd_val : rr.data2;

   datapath_alu u_alu (
      .op     (alu_op),
      .a      (op_x),
      .b      (alu_b),
      .result (alu_res),
      .z      (alu_z),
      .n      (alu_n)
   );

   // Decode the opcode into ALU control, flag enable, memory and branch intent.
   always_comb begin
      alu_op     = ALU_PASS_B;
      alu_b      = op_y;
      sets_flags = 1'b0;
      taken_raw  = 1'b0;
      target     = op_x;
      is_ld      = 1'b0;
      is_st      = 1'b0;
      case (rr.instr[4:0])
         OP_MV:   alu_op = ALU_PASS_B;
         OP_ADD: begin
            alu_op     = ALU_ADD;
            sets_flags = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            alu_op     = ALU_SUB;
            sets_flags = 1'b1;
         end
         OP_MVI:  alu_b = simm8;
         OP_ADDI: begin
            alu_op     = ALU_ADD;
            alu_b      = simm8;
            sets_flags = 1'b1;
         end
         OP_SUBI, OP_CMPI: begin
            alu_op     = ALU_SUB;
            alu_b      = simm8;
            sets_flags = 1'b1;
         end
         OP_MVHI: begin
            alu_op = ALU_HI;
            alu_b  = {8'h00, rr.instr[15:8]};
         end
         OP_LD:   is_ld = 1'b1;
         OP_ST:   is_st = 1'b1;
         OP_JR, OP_CALLR: taken_raw = 1'b1;
         OP_JZ:   taken_raw = z_q;
         OP_JN:   taken_raw = n_q;
         OP_J, OP_CALL: begin
            taken_raw = 1'b1;
            target    = imm_target;
         end
         OP_JZI: begin
            taken_raw = z_q;
            target    = imm_target;
         end
         OP_JNI: begin
            taken_raw = n_q;
            target    = imm_target;
         end
         default: ;
      endcase
   end

   // Side effects leave the stage only for a live, unstalled instruction and
   // never while reset is held, even if upstream still presents valid.
   assign fire          = reset && rr.valid && !i_stall;
   assign o_pc_redirect = fire && taken_raw;
   assign o_flush       = o_pc_redirect;
   assign o_pc_target   = o_pc_redirect ? target : 16'h0000;
   assign o_ldst_rd     = fire && is_ld;
   assign o_ldst_wr     = fire && is_st;
   assign o_ldst_addr   = (o_ldst_rd || o_ldst_wr) ? op_y : 16'h0000;
   assign o_ldst_wrdata = o_ldst_wr ? op_x : 16'h0000;

   // Assemble the next EX_WB bundle from the forwarded operands.
   always_comb begin
      ex_d.taken   = rr.valid && taken_raw;
      ex_d.pc      = rr.pc;
      ex_d.valid   = rr.valid;
      ex_d.data1   = op_x;
      ex_d.data2   = op_y;
      ex_d.alu_out = alu_res;
      ex_d.instr   = rr.instr;
   end

   // EX_WB and flag registers; both freeze while stalled.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!reset) begin
         ex_q <= '0;
         z_q  <= 1'b0;
         n_q  <= 1'b0;
      end else if (!i_stall) begin
         ex_q <= ex_d;
         if (rr.valid && sets_flags) begin
            z_q <= alu_z;
            n_q <= alu_n;
         end
      end
   end

endmodule

// File: doc/datapath_execute.md
# datapath_execute

Execute stage of the 5-stage 16-bit pipelined CPU, between register-read (RR_EX bundle in) and writeback (EX_WB bundle out). It forwards operands from its own output register, computes ALU results and the N/Z flags, and issues load/store strobes to data memory. It also resolves all jumps, branches and calls, driving the PC redirect and the upstream flush. One pipeline register (EX_WB) plus the flag register make up its state.

## Interface
Parameters: none. Widths come from `definesPkg`: `RR_EX_WIDTH` = 65, `EX_WB_WIDTH` = 82.
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `RR_EX`  in  RR_EX_WIDTH  `{PC, valid, data1, data2, instr}`; PC = instr address + 2; data1 = [Rx], data2 = [Ry]
- `i_stall`  in  1  freeze stage (memory/hazard hold)
- `EX_WB`  out  EX_WB_WIDTH  registered `{taken, PC, valid, data1, data2, ALUout, instr}`
- `o_pc_redirect`  out  1  taken control transfer this cycle
- `o_pc_target`  out  16  redirect address
- `o_flush`  out  1  kill fetch/decode/RR contents at this edge
- `o_ldst_addr`  out  16  data memory address
- `o_ldst_wrdata`  out  16  store data
- `o_ldst_rd`  out  1  load strobe
- `o_ldst_wr`  out  1  store strobe

## Operation
- Decode: opcode = instr[4:0], Rx = instr[7:5], Ry = instr[10:8], imm8 = instr[15:8], imm11 = instr[15:5].
- Forwarding from the EX_WB register:
  - Applies when EX_WB.valid and the held instr writes a register: mv/add/sub/mvi/addi/subi/mvhi write Rx; call/callr write r7.
  - On a destination match, the operand is replaced by ALUout, or by EX_WB.PC for call/callr.
  - Applies to Rx and Ry independently.
  - Load-use hazards are not forwarded; upstream stalls them.
- ALU results:
  - mv: Ry
  - add/sub: Rx ± Ry
  - cmp: Rx − Ry
  - mvi: sext(imm8)
  - addi/subi/cmpi: Rx ± sext(imm8)
  - mvhi: {imm8, Rx[7:0]}
  - All arithmetic is 16-bit modulo; carry is discarded.
- Flags:
  - Z = (result == 0), N = result[15].
  - Updated only by add, sub, cmp, addi, subi, cmpi when valid and not stalled.
  - Other instructions leave the flags unchanged.
- Memory:
  - ld: o_ldst_rd = 1, addr = Ry.
  - st: o_ldst_wr = 1, addr = Ry, wrdata = Rx.
  - Both use forwarded values. Strobes are 0 otherwise.
- Control transfers:
  - Register form: jr 01000, jz 01001, jn 01010, callr 01100; target = Rx (forwarded).
  - Immediate form: j 11000, jzi 11001, jni 11010, call 11100; target = PC + (sext(imm11) << 1).
  - j, jr, call, callr are always taken. jz/jzi are taken iff Z; jn/jni iff N.
  - Taken ⇒ o_pc_redirect = o_flush = 1, o_pc_target = target.
  - Not taken ⇒ both 0, o_pc_target = don't-care.
- EX_WB capture: taken, PC, valid, forwarded data1/data2, ALUout, instr. `taken` is 0 for non-branches.

## Timing
- Reset (asynchronous, while low): EX_WB = 0 (valid = 0), Z = N = 0. All combinational outputs read 0 because the input is gated by valid.
- Latency: one cycle from RR_EX to EX_WB.
- Redirect, flush and memory strobes are combinational in the same cycle the instruction sits in execute. Memory read data arrives at writeback the next cycle.
- valid = 0 input:
  - All strobes/redirect/flush = 0; flags hold.
  - The EX_WB register still captures, with valid = 0.
- i_stall = 1:
  - EX_WB and flags hold.
  - Redirect, flush and strobes are forced to 0.
  - The instruction re-evaluates when the stall drops.
- Flag-setting op immediately followed by jz: the branch sees the updated flags, since the flag register updated at the preceding edge.
- Taken branch: execute does not self-squash. Upstream kills the younger instructions at the same edge, and the next RR_EX arrives with valid = 0.
- reset asserted mid-stall or mid-branch: state clears immediately and no redirect is issued.

## Structure
- `definesPkg` holds `RR_EX_WIDTH`, `EX_WB_WIDTH`, opcode constants, and a `writes_reg(instr)` function shared with writeback.
- Sub-module `datapath_alu` is a combinational ALU taking op, A and B, and producing result, z and n.
- The top level holds forwarding, branch resolution, the flag register and the EX_WB register.

## Test plan
- Reset then `mvi r1,#5`, then `addi r1,#-5` back-to-back:
  - EX_WB.ALUout = 0x0005, then 0x0000 via forwarding.
  - Z = 1, N = 0 afterwards.
- `cmp` with r2 = 3, r3 = 7, then `jn r4` (r4 = 0x0040):
  - N = 1; o_pc_redirect = o_flush = 1, o_pc_target = 0x0040.
  - EX_WB.taken = 1.
- `call` at address 0x0010 with imm11 = 0x7FF:
  - o_pc_target = 0x0010.
  - EX_WB.PC = 0x0012.
  - The next instruction reading r7 is forwarded 0x0012.
- `st r1,[r2]` with r1 = 0xBEEF, r2 = 0x0100:
  - o_ldst_wr = 1, addr 0x0100, wrdata 0xBEEF.
  - `ld` gives o_ldst_rd = 1 and no wr.
- `jz` held under i_stall = 1 for 3 cycles:
  - Redirect stays 0 and EX_WB/flags are unchanged.
  - Redirect fires in the first cycle after the stall releases.
- reset low asynchronously mid-cycle while EX_WB.valid = 1: EX_WB.valid = 0 before the next edge, and flags = 0.
